// File: rtl/alu_operand_stage.sv
// ID/EX operand register: captures decoded ALU ops, resolves operands through
// PC/imm muxing and EX/MEM, MEM/WB forwarding, and presents them to the ALU.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_alu_control,
    input  logic [AW-1:0]   in_rs1_addr,
    input  logic [AW-1:0]   in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            in_use_pc,
    input  logic [XLEN-1:0] in_pc,
    input  logic [AW-1:0]   in_rd_addr,
    input  logic            in_reg_write,
    input  logic            exmem_reg_write,
    input  logic [AW-1:0]   exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [AW-1:0]   memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] store_data,
    output logic [AW-1:0]   out_rd_addr,
    output logic            out_reg_write
);

    function automatic logic f_hit(
        input logic          we,
        input logic [AW-1:0] rd,
        input logic [AW-1:0] addr
    );
        return we && (rd == addr) && (addr != '0);
    endfunction

    logic            r_valid;
    logic [3:0]      r_ctrl;
    logic [AW-1:0]   r_rs1_addr;
    logic [AW-1:0]   r_rs2_addr;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic            r_use_imm;
    logic            r_use_pc;
    logic [AW-1:0]   r_rd;
    logic            r_rw;

    logic            w_accept;
    logic            w_drain;
    logic [XLEN-1:0] w_cap_rs1;
    logic [XLEN-1:0] w_cap_rs2;
    logic [XLEN-1:0] w_ref_rs1;
    logic [XLEN-1:0] w_ref_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    assign in_ready = rst_n & (~r_valid | out_ready);
    assign w_accept = in_valid & in_ready & ~flush;
    assign w_drain  = r_valid & out_ready;

    // The regfile write of this cycle is not yet visible, so take MEM/WB.
    assign w_cap_rs1 = f_hit(memwb_reg_write, memwb_rd, in_rs1_addr)
                     ? memwb_result : in_rs1_data;
    assign w_cap_rs2 = f_hit(memwb_reg_write, memwb_rd, in_rs2_addr)
                     ? memwb_result : in_rs2_data;
    assign w_ref_rs1 = f_hit(memwb_reg_write, memwb_rd, r_rs1_addr)
                     ? memwb_result : r_rs1;
    assign w_ref_rs2 = f_hit(memwb_reg_write, memwb_rd, r_rs2_addr)
                     ? memwb_result : r_rs2;

    always_ff @(posedge clk) begin
        if (!rst_n || flush || (w_drain && !w_accept)) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_use_imm  <= 1'b0;
            r_use_pc   <= 1'b0;
            r_rd       <= '0;
            r_rw       <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_ctrl     <= in_alu_control;
            r_rs1_addr <= in_rs1_addr;
            r_rs2_addr <= in_rs2_addr;
            r_rs1      <= w_cap_rs1;
            r_rs2      <= w_cap_rs2;
            r_imm      <= in_imm;
            r_pc       <= in_pc;
            r_use_imm  <= in_use_imm;
            r_use_pc   <= in_use_pc;
            r_rd       <= in_rd_addr;
            r_rw       <= in_reg_write;
        end else if (r_valid) begin
            r_rs1      <= w_ref_rs1;
            r_rs2      <= w_ref_rs2;
        end
    end

    // EX/MEM is the younger producer and wins over MEM/WB.
    assign w_fwd_rs1 = f_hit(exmem_reg_write, exmem_rd, r_rs1_addr) ? exmem_result
                     : w_ref_rs1;
    assign w_fwd_rs2 = f_hit(exmem_reg_write, exmem_rd, r_rs2_addr) ? exmem_result
                     : w_ref_rs2;

    assign out_valid     = r_valid;
    assign alu_control   = r_valid ? r_ctrl : 4'b0000;
    assign a             = !r_valid ? '0 : (r_use_pc  ? r_pc  : w_fwd_rs1);
    assign b             = !r_valid ? '0 : (r_use_imm ? r_imm : w_fwd_rs2);
    assign store_data    = r_valid ? w_fwd_rs2 : '0;
    assign out_rd_addr   = r_rd;
    assign out_reg_write = r_rw;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized checks of alu_operand_stage against a one-slot
// queue model of the ID/EX register.
module tb_alu_operand_stage;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        use_imm;
        logic        use_pc;
        logic [4:0]  rd;
        logic        rw;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [3:0]  in_alu_control;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_use_imm, in_use_pc, in_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        out_valid, out_ready;
    logic [3:0]  alu_control;
    logic [31:0] a, b, store_data;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    int checks = 0;
    int errors = 0;
    op_t slot[$];

    logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                             4'h5, 4'h6, 4'h7, 4'h8, 4'hD};

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_control(in_alu_control),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .in_pc(in_pc), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .a(a), .b(b), .store_data(store_data),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value of a register as seen from MEM/WB, then from EX/MEM on top.
    function automatic logic [31:0] mw(input logic [4:0] ad, input logic [31:0] v);
        return (memwb_reg_write && memwb_rd == ad && ad != 0) ? memwb_result : v;
    endfunction

    function automatic logic [31:0] fw(input logic [4:0] ad, input logic [31:0] v);
        return (exmem_reg_write && exmem_rd == ad && ad != 0) ? exmem_result
                                                              : mw(ad, v);
    endfunction

    function automatic bit m_ready();
        return rst_n && (slot.size() == 0 || out_ready);
    endfunction

    task automatic model_edge();
        op_t n;
        bit  acc;
        acc = in_valid && m_ready() && !flush;
        if (!rst_n || flush) begin
            slot.delete();
        end else if (acc) begin
            n.ctrl = in_alu_control;
            n.ra1 = in_rs1_addr;
            n.ra2 = in_rs2_addr;
            n.v1 = mw(in_rs1_addr, in_rs1_data);
            n.v2 = mw(in_rs2_addr, in_rs2_data);
            n.imm = in_imm;
            n.pc = in_pc;
            n.use_imm = in_use_imm;
            n.use_pc = in_use_pc;
            n.rd = in_rd_addr;
            n.rw = in_reg_write;
            slot.delete();
            slot.push_back(n);
        end else if (slot.size() != 0 && out_ready) begin
            slot.delete();
        end else if (slot.size() != 0) begin
            slot[0].v1 = mw(slot[0].ra1, slot[0].v1);
            slot[0].v2 = mw(slot[0].ra2, slot[0].v2);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        op_t o;
        bit  v;
        #1;
        v = (slot.size() != 0);
        o = v ? slot[0] : '0;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        chk("out_valid", {31'd0, out_valid}, {31'd0, v});
        chk("ctrl", {28'd0, alu_control}, {28'd0, o.ctrl});
        chk("a", a, !v ? 32'd0 : (o.use_pc ? o.pc : fw(o.ra1, o.v1)));
        chk("b", b, !v ? 32'd0 : (o.use_imm ? o.imm : fw(o.ra2, o.v2)));
        chk("store", store_data, v ? fw(o.ra2, o.v2) : 32'd0);
        chk("rd", {27'd0, out_rd_addr}, {27'd0, o.rd});
        chk("rw", {31'd0, out_reg_write}, {31'd0, o.rw});
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_alu_control = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_use_imm = 0; in_use_pc = 0; in_pc = 0;
        in_rd_addr = 0; in_reg_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic send(input logic [3:0] c, input logic [4:0] r1,
                        input logic [31:0] d1, input logic [4:0] r2,
                        input logic [31:0] d2);
        in_valid = 1; in_alu_control = c;
        in_rs1_addr = r1; in_rs1_data = d1;
        in_rs2_addr = r2; in_rs2_data = d2;
        in_rd_addr = 5'd10; in_reg_write = 1;
    endtask

    initial begin
        int n;
        rst_n = 0; out_ready = 1;
        idle();
        @(posedge clk); #1;
        cyc();
        cyc();
        check_all();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_ctrl", {28'd0, alu_control}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);

        rst_n = 1;
        send(4'h0, 5'd5, 32'h10, 5'd6, 32'h5);
        check_all();
        chk("pass_ready", {31'd0, in_ready}, 32'd1);
        cyc(); idle();
        check_all();
        chk("pass_a", a, 32'h10);
        chk("pass_b", b, 32'h5);
        chk("pass_ctrl", {28'd0, alu_control}, 32'h0);
        cyc();

        out_ready = 0;
        send(4'h8, 5'd3, 32'h1, 5'd0, 32'h55);
        cyc(); idle();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h20;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h99;
        check_all();
        chk("fwd_prio_a", a, 32'h20);
        chk("fwd_x0_b", b, 32'h55);
        cyc();
        exmem_rd = 0; exmem_result = 32'h77;
        memwb_rd = 0; memwb_result = 32'h66;
        check_all();
        chk("fwd_refresh_a", a, 32'h99);
        chk("fwd_x0_b2", b, 32'h55);
        idle();
        flush = 1;
        send(4'h4, 5'd1, 32'h1, 5'd2, 32'h2);
        check_all();
        cyc(); idle();
        check_all();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        cyc();

        send(4'h6, 5'd4, 32'h3, 5'd7, 32'h11);
        cyc(); idle();
        memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'hDEADBEEF;
        check_all();
        cyc(); idle();
        check_all();
        cyc();
        check_all();
        cyc();
        out_ready = 1;
        check_all();
        chk("stall_b", b, 32'hDEADBEEF);
        chk("stall_store", store_data, 32'hDEADBEEF);
        cyc();
        check_all();
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        send(4'h0, 5'd1, 32'h5, 5'd9, 32'h1234);
        in_use_pc = 1; in_pc = 32'h100;
        in_use_imm = 1; in_imm = 32'hFFFFFFFC;
        cyc(); idle();
        exmem_reg_write = 1; exmem_rd = 9; exmem_result = 32'hABCD;
        check_all();
        chk("imm_a", a, 32'h100);
        chk("imm_b", b, 32'hFFFFFFFC);
        chk("imm_store", store_data, 32'hABCD);
        cyc(); idle();

        n = 0;
        for (int i = 0; i < 8; i++) begin
            send(ops[i], 5'd2, 32'(i), 5'd3, 32'(i + 100));
            check_all();
            if (out_valid) n++;
            if (i > 0) chk("stream_ctrl", {28'd0, alu_control}, {28'd0, ops[i-1]});
            cyc();
        end
        idle();
        check_all();
        if (out_valid) n++;
        chk("stream_ctrl", {28'd0, alu_control}, {28'd0, ops[7]});
        cyc();
        chk("stream_count", n, 32'd8);

        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom % 50) != 0;
            flush = ($urandom % 12) == 0;
            out_ready = ($urandom % 4) != 0;
            in_valid = ($urandom % 4) != 0;
            in_alu_control = ops[$urandom % 10];
            in_rs1_addr = 5'($urandom % 8);
            in_rs2_addr = 5'($urandom % 8);
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_imm = $urandom;
            in_pc = $urandom;
            in_use_imm = 1'($urandom);
            in_use_pc = 1'($urandom);
            in_rd_addr = 5'($urandom);
            in_reg_write = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_rd = 5'($urandom % 8);
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd = 5'($urandom % 8);
            memwb_result = $urandom;
            check_all();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
